// File: rtl/change_dispenser.sv
// Vend/change actuator sequencer downstream of the vending controller.
// One vend pulse, then one coin_out pulse per nickel owed.
module change_dispenser #(
    parameter int PULSE_CYC = 50000,
    parameter int GAP_CYC   = 50000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       dispense,
    input  logic       collect,
    input  logic [3:0] amount,
    output logic       vend_pulse,
    output logic       coin_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] change_left
);

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        PAY_ON,
        PAY_OFF,
        DONE,
        WAIT_CLR
    } state_t;

    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  count_q, count_d;
    logic        dispense_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 16'd1;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (dispense && !dispense_q) begin
                    state_d = VEND;
                    count_d = collect ? amount : 4'd0;
                end
            end
            VEND: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    state_d = (count_q != 4'd0) ? PAY_ON : DONE;
                end
            end
            PAY_ON: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    count_d = (count_q != 4'd0) ? count_q - 4'd1 : 4'd0;
                    state_d = (count_d != 4'd0) ? PAY_OFF : DONE;
                end
            end
            PAY_OFF: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = PAY_ON;
                end
            end
            DONE: begin
                timer_d = '0;
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                timer_d = '0;
                if (!dispense) state_d = IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the current state, so they trail the state by one clock.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            count_q     <= '0;
            dispense_q  <= 1'b0;
            vend_pulse  <= 1'b0;
            coin_out    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            change_left <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            dispense_q  <= dispense;
            vend_pulse  <= (state_q == VEND);
            coin_out    <= (state_q == PAY_ON);
            busy        <= (state_q != IDLE);
            done        <= (state_q == DONE);
            change_left <= (state_q == IDLE) ? 4'd0 : count_q;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: trace-generating model plus
// directed transactions with literal expectations.
module tb_change_dispenser;

    localparam int PULSE = 4;
    localparam int GAP   = 3;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       dispense = 1'b0;
    logic       collect = 1'b0;
    logic [3:0] amount = 4'd0;
    logic       vend_pulse, coin_out, busy, done;
    logic [3:0] change_left;

    int checks = 0;
    int errors = 0;

    change_dispenser #(
        .PULSE_CYC(PULSE),
        .GAP_CYC  (GAP)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .dispense   (dispense),
        .collect    (collect),
        .amount     (amount),
        .vend_pulse (vend_pulse),
        .coin_out   (coin_out),
        .busy       (busy),
        .done       (done),
        .change_left(change_left)
    );

    always #5 clk = ~clk;

    // Output tuple: {vend, coin, busy, done, change_left}
    logic [7:0] trace_q[$];
    logic [7:0] exp_v = 8'h00;
    int         mode = 0;
    logic       prev_d = 1'b0;

    function automatic void build(input logic [3:0] c);
        for (int k = 0; k < PULSE; k++) trace_q.push_back({4'hA, c});
        for (int i = int'(c); i >= 1; i--) begin
            for (int k = 0; k < PULSE; k++) trace_q.push_back({4'h6, 4'(i)});
            if (i > 1)
                for (int k = 0; k < GAP; k++) trace_q.push_back({4'h2, 4'(i - 1)});
        end
        trace_q.push_back(8'h30);
    endfunction

    // Model: idle -> whole-transaction trace -> hold busy until dispense low
    initial forever begin
        @(posedge clk);
        if (RST) begin
            trace_q.delete();
            mode   = 0;
            prev_d = 1'b0;
            exp_v  = 8'h00;
        end else begin
            case (mode)
                0: begin
                    exp_v = 8'h00;
                    if (dispense && !prev_d) begin
                        build(collect ? amount : 4'd0);
                        mode = 1;
                    end
                end
                1: begin
                    exp_v = trace_q.pop_front();
                    if (trace_q.size() == 0) mode = 2;
                end
                default: begin
                    exp_v = 8'h20;
                    if (!dispense) mode = 0;
                end
            endcase
            prev_d = dispense;
        end
    end

    initial begin
        logic [7:0] act, expv;
        logic       prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            act  = {vend_pulse, coin_out, busy, done, change_left};
            expv = RST ? 8'h00 : exp_v;
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle t=%0t actual=%h required=%h", $time, act, expv);
            end
            checks++;
            if (vend_pulse && coin_out) begin
                errors++;
                $display("FAIL exclusive t=%0t actual=vend&coin required=not both", $time);
            end
            checks++;
            if (done && prev_done) begin
                errors++;
                $display("FAIL done_width t=%0t actual=2+ cycles required=1", $time);
            end
            prev_done = done;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic run_txn(input logic c, input logic [3:0] a, input bit poke,
                           output int nv, output int nc, output int nb,
                           output int fv, output logic [11:0] cls);
        logic pc;
        int   seen;
        int   pk;
        @(negedge clk);
        dispense = 1'b1;
        collect  = c;
        amount   = a;
        nv = 0; nc = 0; nb = 0; fv = -1; cls = '0;
        pc = 1'b0; seen = 0; pk = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (vend_pulse) begin
                nv++;
                if (fv < 0) fv = i;
            end
            if (coin_out && !pc) begin
                nc++;
                cls = {cls[7:0], change_left};
            end
            pc = coin_out;
            if (busy) nb++;
            if (done) begin
                seen = 1;
                break;
            end
            if (poke) begin
                if (pk == 1) begin
                    dispense = 1'b1;
                    amount   = 4'd9;
                    pk       = 2;
                end else if (pk == 0 && coin_out) begin
                    dispense = 1'b0;
                    pk       = 1;
                end
            end
        end
        chk("done_reached", seen, 1);
    endtask

    task automatic end_clr();
        dispense = 1'b0;
        @(negedge clk);
        chk("busy_after_drop", busy, 1);
        @(negedge clk);
        chk("busy_cleared", busy, 0);
    endtask

    initial begin
        int          nv, nc, nb, fv, bad, found;
        logic [11:0] cls;

        build(4'd3);
        chk("model_len3", trace_q.size(), 23);
        trace_q.delete();
        build(4'd15);
        chk("model_len15", trace_q.size(), 107);
        trace_q.delete();
        build(4'd0);
        chk("model_len0", trace_q.size(), 5);
        trace_q.delete();

        repeat (2) @(negedge clk);
        chk("reset_outs", int'({vend_pulse, coin_out, busy, done, change_left}), 0);
        RST = 1'b0;
        @(negedge clk);
        chk("idle_outs", int'({vend_pulse, coin_out, busy, done, change_left}), 0);

        run_txn(1'b0, 4'd0, 1'b0, nv, nc, nb, fv, cls);
        chk("t1_vend_cycles", nv, 4);
        chk("t1_first_vend", fv, 2);
        chk("t1_coins", nc, 0);
        chk("t1_busy_cycles", nb, 5);
        end_clr();

        run_txn(1'b1, 4'd3, 1'b0, nv, nc, nb, fv, cls);
        chk("t2_vend_cycles", nv, 4);
        chk("t2_coins", nc, 3);
        chk("t2_busy_cycles", nb, 23);
        chk("t2_change_steps", int'(cls), 'h321);
        chk("t2_change_end", int'(change_left), 0);
        end_clr();

        run_txn(1'b1, 4'd2, 1'b1, nv, nc, nb, fv, cls);
        chk("t3_vend_cycles", nv, 4);
        chk("t3_coins", nc, 2);
        chk("t3_busy_cycles", nb, 16);

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy || vend_pulse || coin_out) bad++;
        end
        chk("t4_wait_clr_hold", bad, 0);
        end_clr();
        run_txn(1'b1, 4'd1, 1'b0, nv, nc, nb, fv, cls);
        chk("t4_coins", nc, 1);
        chk("t4_busy_cycles", nb, 9);
        end_clr();

        run_txn(1'b1, 4'd15, 1'b0, nv, nc, nb, fv, cls);
        chk("t5_coins15", nc, 15);
        chk("t5_busy15", nb, 107);
        end_clr();
        run_txn(1'b1, 4'd0, 1'b0, nv, nc, nb, fv, cls);
        chk("t5_coins0", nc, 0);
        chk("t5_busy0", nb, 5);
        end_clr();

        @(negedge clk);
        dispense = 1'b1;
        collect  = 1'b1;
        amount   = 4'd5;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (coin_out) begin
                found = 1;
                break;
            end
        end
        chk("t6_coin_seen", found, 1);
        @(negedge clk);
        chk("t6_coin_before_rst", coin_out, 1);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_coin", coin_out, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_change", change_left, 0);
        chk("t6_rst_vend", vend_pulse, 0);
        dispense = 1'b0;
        collect  = 1'b0;
        amount   = 4'd0;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        run_txn(1'b0, 4'd0, 1'b0, nv, nc, nb, fv, cls);
        chk("t6_fresh_vend", nv, 4);
        chk("t6_fresh_first", fv, 2);
        chk("t6_fresh_busy", nb, 5);
        end_clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
